// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    localparam int BURST_DEF = 4;

endpackage

// File: rtl/dm_arb_grant.sv
// Combinational grant decision and next-state for the data-memory arbiter.
module dm_arb_grant
    import dm_arb_pkg::*;
#(
    parameter int BURST = BURST_DEF,
    localparam int CW = $clog2(BURST + 1)
) (
    input  state_t          state,
    input  logic [CW-1:0]   cnt,
    input  logic            rr_ptr,
    input  logic            v0,
    input  logic            v1,
    output logic            gnt_vld,
    output logic            gnt,
    output state_t          nxt_state,
    output logic [CW-1:0]   nxt_cnt,
    output logic            nxt_rr
);

    localparam logic [CW-1:0] CMAX = CW'(BURST);

    logic own0, own1, idle;
    logic keep0, keep1, take0, take1;

    assign own0  = (state == OWN0);
    assign own1  = (state == OWN1);
    assign idle  = (state == IDLE);
    assign keep0 = own0 & v0 & ((cnt < CMAX) | ~v1);
    assign keep1 = own1 & v1 & ((cnt < CMAX) | ~v0);
    assign take1 = own0 & v1 & ~keep0;
    assign take0 = own1 & v0 & ~keep1;

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = 1'b0;
        unique case (1'b1)
            keep0:             begin gnt_vld = 1'b1; gnt = 1'b0;   end
            keep1:             begin gnt_vld = 1'b1; gnt = 1'b1;   end
            take1:             begin gnt_vld = 1'b1; gnt = 1'b1;   end
            take0:             begin gnt_vld = 1'b1; gnt = 1'b0;   end
            idle & v0 & v1:    begin gnt_vld = 1'b1; gnt = rr_ptr; end
            idle & v0 & ~v1:   begin gnt_vld = 1'b1; gnt = 1'b0;   end
            idle & ~v0 & v1:   begin gnt_vld = 1'b1; gnt = 1'b1;   end
            default: ;
        endcase
    end

    // Beat count saturates so a lone owner can stream indefinitely.
    always_comb begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
        nxt_rr    = rr_ptr;
        if (gnt_vld) begin
            nxt_state = gnt ? OWN1 : OWN0;
            nxt_rr    = ~gnt;
            if (state == nxt_state)
                nxt_cnt = (cnt < CMAX) ? cnt + 1'b1 : CMAX;
            else
                nxt_cnt = CW'(1);
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported data memory.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int BURST = BURST_DEF,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic [31:0]   req0_pc,
    output logic          req0_ready,
    output logic          req0_rvalid,
    output logic [DW-1:0] req0_rdata,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    input  logic [31:0]   req1_pc,
    output logic          req1_ready,
    output logic          req1_rvalid,
    output logic [DW-1:0] req1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic [31:0]   mem_pc,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(BURST + 1);

    state_t        state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic          rr_ptr, nxt_rr;
    logic          gnt_vld, gnt;
    logic          v0, v1;
    logic          ld0, ld1;

    // Masking the valids keeps the memory quiet while reset is held.
    assign v0 = req0_valid & ~reset;
    assign v1 = req1_valid & ~reset;

    dm_arb_grant #(.BURST(BURST)) u_grant (
        .state     (state),
        .cnt       (cnt),
        .rr_ptr    (rr_ptr),
        .v0        (v0),
        .v1        (v1),
        .gnt_vld   (gnt_vld),
        .gnt       (gnt),
        .nxt_state (nxt_state),
        .nxt_cnt   (nxt_cnt),
        .nxt_rr    (nxt_rr)
    );

    assign req0_ready = gnt_vld & ~gnt;
    assign req1_ready = gnt_vld & gnt;
    assign ld0 = req0_ready & ~req0_we;
    assign ld1 = req1_ready & ~req1_we;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_pc    = '0;
        if (req0_ready) begin
            mem_addr  = req0_addr;
            mem_wdata = req0_wdata;
            mem_we    = req0_we;
            mem_pc    = req0_pc;
        end else if (req1_ready) begin
            mem_addr  = req1_addr;
            mem_wdata = req1_wdata;
            mem_we    = req1_we;
            mem_pc    = req1_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rr_ptr      <= 1'b0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            rr_ptr      <= nxt_rr;
            req0_rvalid <= ld0;
            req1_rvalid <= ld1;
            if (ld0)
                req0_rdata <= mem_rdata;
            if (ld1)
                req1_rdata <= mem_rdata;
        end
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter placed in front of the single-ported data memory, sharing it between the pipeline load/store port (port 0) and a second requester such as a debug or loader port (port 1). It accepts at most one access per cycle, picks the winner round-robin with bounded bursts, drives the memory's address, write-data and write-enable, and returns registered read data one cycle after a read is accepted.

## Interface
- BURST, 4: max consecutive beats one port keeps ownership while the other waits (≥1)
- AW, 32: address width
- DW, 32: data width

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- req0_valid / req1_valid  in  1  access request
- req0_we / req1_we  in  1  1 = store, 0 = load
- req0_addr / req1_addr  in  AW  byte address, passed through unchanged
- req0_wdata / req1_wdata  in  DW  store data
- req0_pc / req1_pc  in  32  PC of the requesting instruction, forwarded for the store trace
- req0_ready / req1_ready  out  1  grant; the access is accepted on a clock edge where valid&ready
- req0_rvalid / req1_rvalid  out  1  load data valid
- req0_rdata / req1_rdata  out  DW  registered load data
- mem_addr  out  AW  to memory address
- mem_wdata  out  DW  to memory write data
- mem_we  out  1  to memory write enable
- mem_pc  out  32  to memory trace PC
- mem_rdata  in  DW  combinational read data from memory

## Operation
- State: state ∈ {IDLE, OWN0, OWN1}; cnt (0..BURST) counts beats in the current ownership; rr_ptr (1 bit) marks the preferred port when ownership is free.
- Grant, combinational each cycle:
  - OWNx, reqx_valid, and (cnt < BURST or other port not valid) → grant x.
  - Otherwise, if the other port is valid → grant it.
  - IDLE with both valid → grant rr_ptr; IDLE with one valid → grant that port.
  - No valid → no grant.
- On grant g:
  - ready_g = 1.
  - mem_* driven from port g; mem_we = req_g_we.
  - Next state = OWNg; rr_ptr ← ~g.
  - cnt ← (state == OWNg) ? min(cnt+1, BURST) : 1.
- No grant: mem_addr/mem_wdata/mem_pc = 0, mem_we = 0; next state IDLE, cnt ← 0.
- Loads: on an accepted load, rdata_g ← mem_rdata at that edge and rvalid_g = 1 for exactly the next cycle. rdata holds its value until the next load on that port.
- Stores complete at the accept edge and produce no rvalid.
- A port never sees ready while the other is granted. At most one ready is high per cycle.

## Timing
- ready is a combinational function of the valids and registered state. Requesters must not make valid depend on ready.
- Load latency: one cycle from the accept edge to rvalid. Back-to-back accepts are allowed, one per cycle. A store followed by a load to the same address on the next cycle returns the new data.
- Reset values: state IDLE, cnt 0, rr_ptr 0, rvalid 0, rdata 0. mem_we = 0 while reset is high.
- Reset mid-operation: a pending rvalid is dropped, and the first grant after reset follows the IDLE rule with rr_ptr = 0.
- Simultaneous valid on the BURST-th owner beat: the other port wins on the next cycle.

## Structure
- Package dm_arb_pkg holds the state enum (IDLE/OWN0/OWN1) and the default BURST constant.
- One sub-module, dm_arb_grant, holds the combinational grant/next-state logic. The top level holds the registers, the memory-port mux and the rdata capture.

## Test plan
- Memory word 4 = 0xDEADBEEF; req0 loads 0x10 alone → ready0 = 1 in the same cycle, rvalid0 = 1 with rdata0 = 0xDEADBEEF next cycle, ready1 never 1.
- Both valid from reset and held → 4 beats to port 0, then 4 to port 1, alternating, no idle cycles.
- req0 streams 10 beats alone → all 10 accepted back-to-back; req1 raises valid during beat 6 → port 1 granted the following cycle.
- req1 stores 0x12345678 to 0x20, then req0 loads 0x20 on the next cycle → mem_we = 1 only on the store beat; rdata0 = 0x12345678.
- Reset pulsed between a load accept and its rvalid edge → rvalid0 stays 0; with both then valid, port 0 is granted first.
- Owner drops valid for one cycle with the other port idle → state IDLE; on the next owner request cnt restarts at 1.
